// File: rtl/fetch_pc_gen_if.sv
// Fetch request bus between the PC generator (master) and the instruction bus (slave).
`timescale 1ns/1ps
interface fetch_pc_gen_if #(
  parameter int unsigned EPOCH_W = 2
);
  logic               req_valid;
  logic               req_ready;
  logic [31:0]        req_addr;
  logic               req_adel;
  logic [EPOCH_W-1:0] req_epoch;

  modport master (
    output req_valid, req_addr, req_adel, req_epoch,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_adel, req_epoch,
    output req_ready
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC generator and fetch-request issuer: arbitrates exception/ERET/branch
// redirects, holds requests stable until accepted, and tags them with an epoch.
`timescale 1ns/1ps
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR  = 32'hbfc00380,
  parameter int unsigned NUM_BR      = 2,
  parameter int unsigned FETCH_WIDTH = 1,
  parameter int unsigned EPOCH_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  exc_valid,
  input  logic                  eret_valid,
  input  logic [31:0]           epc,
  input  logic [NUM_BR-1:0]     br_valid,
  input  logic [NUM_BR*32-1:0]  br_target,
  output logic [EPOCH_W-1:0]    cur_epoch,
  fetch_pc_gen_if.master        fbus
);

  localparam logic [31:0] STEP = 32'(4 * FETCH_WIDTH);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [EPOCH_W-1:0] req_epoch_q, req_epoch_d;
  logic               pend_valid_q, pend_valid_d;
  logic [31:0]        pend_addr_q, pend_addr_d;

  logic               redir;
  logic               br_hit;
  logic [31:0]        redir_tgt;
  logic [31:0]        seq_pc;

  // Branch channels scanned lowest-index first; ERET then exception override on top.
  always_comb begin
    redir_tgt = '0;
    br_hit    = 1'b0;
    for (int unsigned i = 0; i < NUM_BR; i++) begin
      if (!br_hit && br_valid[i]) begin
        redir_tgt = br_target[32*i +: 32];
        br_hit    = 1'b1;
      end
    end
    if (eret_valid) redir_tgt = epc;
    if (exc_valid)  redir_tgt = EXC_VECTOR;
    redir = exc_valid | eret_valid | (|br_valid);
  end

  assign seq_pc = (pc_q & ~(STEP - 32'd1)) + STEP;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epoch_d      = epoch_q + EPOCH_W'(redir);
    req_epoch_d  = req_epoch_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    unique case (state_q)
      IDLE: begin
        if (redir) pc_d = redir_tgt;
        if (!stall) begin
          state_d     = REQ;
          req_epoch_d = epoch_d;
        end
      end
      REQ: begin
        if (fbus.req_ready) begin
          pc_d         = redir ? redir_tgt : (pend_valid_q ? pend_addr_q : seq_pc);
          pend_valid_d = 1'b0;
          if (!stall) begin
            state_d     = REQ;
            req_epoch_d = epoch_d;
          end else begin
            state_d = IDLE;
          end
        end else if (redir) begin
          // Held request keeps pc stable; the redirect waits in pend until accept.
          pend_valid_d = 1'b1;
          pend_addr_d  = redir_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      epoch_q      <= '0;
      req_epoch_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      req_epoch_q  <= req_epoch_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign fbus.req_valid = (state_q == REQ);
  assign fbus.req_addr  = pc_q;
  assign fbus.req_adel  = |pc_q[1:0];
  assign fbus.req_epoch = req_epoch_q;
  assign cur_epoch      = epoch_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed vector table, hand sequences and a randomized
// run against a transaction-level model, on FETCH_WIDTH=1 and FETCH_WIDTH=2 instances.
`timescale 1ns/1ps
module tb_fetch_pc_gen;

  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC = 32'hbfc00380;

  typedef struct {
    logic        stall, exc, eret;
    logic [31:0] epc;
    logic [1:0]  brv;
    logic [63:0] brt;
    logic        ready;
  } in_t;

  typedef struct {
    in_t         in;
    logic        ev;
    logic [31:0] ea;
    logic        eadel;
    logic [1:0]  etag;
    logic [1:0]  ecur;
  } vec_t;

  typedef struct {
    logic        busy;
    logic [31:0] pc;
    logic        pend_v;
    logic [31:0] pend_a;
    int unsigned epoch;
    int unsigned tag;
  } mdl_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, exc_valid, eret_valid;
  logic [31:0] epc;
  logic [1:0]  br_valid;
  logic [63:0] br_target;
  logic [1:0]  cur1, cur2;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  mdl_t m1, m2;
  vec_t tbl[16];

  fetch_pc_gen_if #(.EPOCH_W(2)) bus1 ();
  fetch_pc_gen_if #(.EPOCH_W(2)) bus2 ();

  fetch_pc_gen #(.FETCH_WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall), .exc_valid(exc_valid),
    .eret_valid(eret_valid), .epc(epc), .br_valid(br_valid),
    .br_target(br_target), .cur_epoch(cur1), .fbus(bus1.master)
  );

  fetch_pc_gen #(.FETCH_WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .stall(stall), .exc_valid(exc_valid),
    .eret_valid(eret_valid), .epc(epc), .br_valid(br_valid),
    .br_target(br_target), .cur_epoch(cur2), .fbus(bus2.master)
  );

  always #5 clk = ~clk;

  function automatic in_t mkin(logic st, logic ex, logic er, logic [31:0] ep,
                               logic [1:0] bv, logic [63:0] bt, logic rd);
    in_t v;
    v.stall = st; v.exc = ex; v.eret = er; v.epc = ep;
    v.brv = bv; v.brt = bt; v.ready = rd;
    return v;
  endfunction

  function automatic vec_t mk(in_t v, logic ev, logic [31:0] ea, logic eadel,
                              logic [1:0] etag, logic [1:0] ecur);
    vec_t r;
    r.in = v; r.ev = ev; r.ea = ea; r.eadel = eadel; r.etag = etag; r.ecur = ecur;
    return r;
  endfunction

  function automatic mdl_t mdl_reset();
    mdl_t s;
    s.busy = 1'b0; s.pc = RST_PC; s.pend_v = 1'b0; s.pend_a = '0;
    s.epoch = 0; s.tag = 0;
    return s;
  endfunction

  // One clock of the fetch front end described at transaction level.
  function automatic mdl_t mdl_next(mdl_t s, int unsigned step, in_t v);
    mdl_t        n;
    logic        redir;
    logic [31:0] tgt;
    n = s;
    redir = 1'b1;
    if (v.exc)         tgt = EXC_PC;
    else if (v.eret)   tgt = v.epc;
    else if (v.brv[0]) tgt = v.brt[31:0];
    else if (v.brv[1]) tgt = v.brt[63:32];
    else begin redir = 1'b0; tgt = '0; end
    n.epoch = (s.epoch + (redir ? 1 : 0)) % 4;
    if (s.busy && v.ready) begin
      if (redir)         n.pc = tgt;
      else if (s.pend_v) n.pc = s.pend_a;
      else               n.pc = s.pc - (s.pc % step) + step;
      n.pend_v = 1'b0;
      n.busy = !v.stall;
      if (!v.stall) n.tag = n.epoch;
    end else if (s.busy) begin
      if (redir) begin n.pend_v = 1'b1; n.pend_a = tgt; end
    end else begin
      if (redir) n.pc = tgt;
      if (!v.stall) begin n.busy = 1'b1; n.tag = n.epoch; end
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input in_t v);
    stall = v.stall; exc_valid = v.exc; eret_valid = v.eret; epc = v.epc;
    br_valid = v.brv; br_target = v.brt;
    bus1.req_ready = v.ready; bus2.req_ready = v.ready;
  endtask

  task automatic chk_mdl();
    chk("mdl1_valid", 32'(bus1.req_valid), 32'(m1.busy));
    chk("mdl1_cur",   32'(cur1), m1.epoch);
    if (m1.busy) begin
      chk("mdl1_addr", bus1.req_addr, m1.pc);
      chk("mdl1_adel", 32'(bus1.req_adel), 32'(|m1.pc[1:0]));
      chk("mdl1_tag",  32'(bus1.req_epoch), m1.tag);
    end
    chk("mdl2_valid", 32'(bus2.req_valid), 32'(m2.busy));
    chk("mdl2_cur",   32'(cur2), m2.epoch);
    if (m2.busy) begin
      chk("mdl2_addr", bus2.req_addr, m2.pc);
      chk("mdl2_adel", 32'(bus2.req_adel), 32'(|m2.pc[1:0]));
      chk("mdl2_tag",  32'(bus2.req_epoch), m2.tag);
    end
  endtask

  // Drive one cycle; outputs sampled at the falling edge, before the consuming edge.
  task automatic run_cycle(input in_t v);
    apply(v);
    @(negedge clk);
    chk_mdl();
    m1 = mdl_next(m1, 4, v);
    m2 = mdl_next(m2, 8, v);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input int unsigned sel);
    apply(t.in);
    @(negedge clk);
    if (sel == 0) begin
      chk("vec1_valid", 32'(bus1.req_valid), 32'(t.ev));
      chk("vec1_cur",   32'(cur1), 32'(t.ecur));
      if (t.ev) begin
        chk("vec1_addr", bus1.req_addr, t.ea);
        chk("vec1_adel", 32'(bus1.req_adel), 32'(t.eadel));
        chk("vec1_tag",  32'(bus1.req_epoch), 32'(t.etag));
      end
    end else begin
      chk("vec2_valid", 32'(bus2.req_valid), 32'(t.ev));
      chk("vec2_cur",   32'(cur2), 32'(t.ecur));
      if (t.ev) begin
        chk("vec2_addr", bus2.req_addr, t.ea);
        chk("vec2_adel", 32'(bus2.req_adel), 32'(t.eadel));
        chk("vec2_tag",  32'(bus2.req_epoch), 32'(t.etag));
      end
    end
    chk_mdl();
    m1 = mdl_next(m1, 4, t.in);
    m2 = mdl_next(m2, 8, t.in);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m1 = mdl_reset();
    m2 = mdl_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    in_t idle, nrdy, rv;
    idle = mkin(0, 0, 0, '0, 2'b00, '0, 1);
    nrdy = mkin(0, 0, 0, '0, 2'b00, '0, 0);
    apply(idle);
    do_reset();

    // Sequential issue, held request with branch, collision priority, epoch wrap, misalign.
    tbl[0]  = mk(idle, 0, RST_PC, 0, 0, 0);
    tbl[1]  = mk(idle, 1, 32'hbfc00000, 0, 0, 0);
    tbl[2]  = mk(idle, 1, 32'hbfc00004, 0, 0, 0);
    tbl[3]  = mk(nrdy, 1, 32'hbfc00008, 0, 0, 0);
    tbl[4]  = mk(mkin(0, 0, 0, '0, 2'b10, {32'h80001000, 32'h0}, 0), 1, 32'hbfc00008, 0, 0, 0);
    tbl[5]  = mk(nrdy, 1, 32'hbfc00008, 0, 0, 1);
    tbl[6]  = mk(idle, 1, 32'hbfc00008, 0, 0, 1);
    tbl[7]  = mk(mkin(0, 1, 1, 32'h80000040, 2'b01, {32'h0, 32'h80002000}, 1), 1, 32'h80001000, 0, 1, 1);
    tbl[8]  = mk(mkin(0, 0, 0, '0, 2'b01, {32'h0, 32'h80000100}, 1), 1, 32'hbfc00380, 0, 2, 2);
    tbl[9]  = mk(mkin(0, 0, 0, '0, 2'b10, {32'h80000200, 32'h0}, 1), 1, 32'h80000100, 0, 3, 3);
    tbl[10] = mk(mkin(0, 0, 1, 32'h80000300, 2'b00, '0, 1), 1, 32'h80000200, 0, 0, 0);
    tbl[11] = mk(mkin(1, 0, 0, '0, 2'b00, '0, 1), 1, 32'h80000300, 0, 1, 1);
    tbl[12] = mk(mkin(1, 0, 0, '0, 2'b01, {32'h0, 32'h80000002}, 1), 0, 32'h80000304, 0, 1, 1);
    tbl[13] = mk(nrdy, 0, 32'h80000002, 0, 2, 2);
    tbl[14] = mk(idle, 1, 32'h80000002, 1, 2, 2);
    tbl[15] = mk(idle, 1, 32'h80000004, 0, 2, 2);
    for (int i = 0; i < 16; i++) run_vec(tbl[i], 0);

    // FETCH_WIDTH=2: aligned-group sequencing after a mid-group redirect.
    do_reset();
    run_vec(mk(mkin(0, 0, 0, '0, 2'b01, {32'h0, 32'h80000004}, 1), 0, '0, 0, 0, 0), 1);
    run_vec(mk(idle, 1, 32'h80000004, 0, 1, 1), 1);
    run_vec(mk(idle, 1, 32'h80000008, 0, 1, 1), 1);

    // Reset asserted while a request is held with a redirect pending.
    run_vec(mk(nrdy, 1, 32'h8000000c, 0, 1, 1), 0);
    run_vec(mk(mkin(0, 0, 0, '0, 2'b01, {32'h0, 32'h80003000}, 0), 1, 32'h8000000c, 0, 1, 1), 0);
    reset = 1'b1;
    #1;
    chk("rst_async_valid1", 32'(bus1.req_valid), 32'd0);
    chk("rst_async_valid2", 32'(bus2.req_valid), 32'd0);
    chk("rst_async_cur1",   32'(cur1), 32'd0);
    m1 = mdl_reset();
    m2 = mdl_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_vec(mk(idle, 0, RST_PC, 0, 0, 0), 0);
    run_vec(mk(idle, 1, 32'hbfc00000, 0, 0, 0), 0);
    run_vec(mk(idle, 1, 32'hbfc00004, 0, 0, 0), 0);

    // Randomized traffic against the model on both instances.
    for (int i = 0; i < 1500; i++) begin
      rv.stall = ($urandom_range(0, 3) == 0);
      rv.exc   = ($urandom_range(0, 24) == 0);
      rv.eret  = ($urandom_range(0, 19) == 0);
      rv.epc   = $urandom;
      rv.brv[0] = ($urandom_range(0, 7) == 0);
      rv.brv[1] = ($urandom_range(0, 7) == 0);
      rv.brt   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) rv.brt = rv.brt & 64'hfffffffc_fffffffc;
      rv.ready = ($urandom_range(0, 2) != 0);
      run_cycle(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
